// File: rtl/exc_entry_ctrl.sv
// Exception/interrupt entry and ERET return sequencer between the M stage, CP0 and the fetch PC mux.
// Arbitrates int > exc > eret on valid M-stage instructions and drives registered CP0 strobes, flush and redirect.
module exc_entry_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_is_eret,
  input  logic        int_req,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        epc_we,
  output logic [31:0] epc_data,
  output logic [4:0]  exc_code,
  output logic        bd,
  output logic        flush,
  output logic        stall_req,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ENTER = 2'd2,
    S_ERET  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ev_pc_q, ev_pc_d;
  logic [4:0]    ev_code_q, ev_code_d;
  logic          ev_bd_q, ev_bd_d;

  logic          exl_set_q, exl_set_d;
  logic          exl_clr_q, exl_clr_d;
  logic          epc_we_q, epc_we_d;
  logic [31:0]   epc_data_q, epc_data_d;
  logic [4:0]    exc_code_q, exc_code_d;
  logic          bd_q, bd_d;
  logic          flush_q, flush_d;
  logic          stall_req_q, stall_req_d;
  logic          pc_redirect_q, pc_redirect_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          busy_q, busy_d;

  // Live event decode; interrupt wins over exception, which wins over ERET
  logic          entry_ev;
  logic          eret_ev;
  logic [31:0]   cap_pc;
  logic [4:0]    cap_code;

  assign entry_ev = m_valid & (int_req | m_exc);
  assign eret_ev  = m_valid & m_is_eret & ~int_req & ~m_exc;
  assign cap_pc   = m_bd ? (m_pc - 32'd4) : m_pc;
  assign cap_code = int_req ? 5'd0 : m_exc_code;

  logic          fire;
  logic [31:0]   fire_pc;
  logic [4:0]    fire_code;
  logic          fire_bd;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ev_pc_d       = ev_pc_q;
    ev_code_d     = ev_code_q;
    ev_bd_d       = ev_bd_q;
    exl_set_d     = 1'b0;
    exl_clr_d     = 1'b0;
    epc_we_d      = 1'b0;
    epc_data_d    = epc_data_q;
    exc_code_d    = exc_code_q;
    bd_d          = bd_q;
    flush_d       = 1'b0;
    stall_req_d   = 1'b0;
    pc_redirect_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    fire          = 1'b0;
    fire_pc       = ev_pc_q;
    fire_code     = ev_code_q;
    fire_bd       = ev_bd_q;

    unique case (state_q)
      S_IDLE: begin
        if (entry_ev) begin
          ev_pc_d   = cap_pc;
          ev_code_d = cap_code;
          ev_bd_d   = m_bd;
          if (mem_busy) begin
            state_d     = S_WAIT;
            stall_req_d = 1'b1;
          end else begin
            fire      = 1'b1;
            fire_pc   = cap_pc;
            fire_code = cap_code;
            fire_bd   = m_bd;
          end
        end else if (eret_ev) begin
          state_d       = S_ERET;
          exl_clr_d     = 1'b1;
          pc_redirect_d = 1'b1;
          flush_d       = 1'b1;
          redirect_pc_d = cp0_epc;
        end
      end
      S_WAIT: begin
        if (mem_busy) begin
          stall_req_d = 1'b1;
        end else begin
          fire = 1'b1;
        end
      end
      S_ENTER: begin
        // Counter holds the number of flush cycles still owed after this one
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          flush_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERET: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fire) begin
      state_d       = S_ENTER;
      cnt_d         = CW'(FLUSH_CYCLES - 1);
      exl_set_d     = 1'b1;
      epc_we_d      = 1'b1;
      pc_redirect_d = 1'b1;
      flush_d       = 1'b1;
      epc_data_d    = fire_pc;
      exc_code_d    = fire_code;
      bd_d          = fire_bd;
      redirect_pc_d = HANDLER_ADDR;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ev_pc_q       <= '0;
      ev_code_q     <= '0;
      ev_bd_q       <= 1'b0;
      exl_set_q     <= 1'b0;
      exl_clr_q     <= 1'b0;
      epc_we_q      <= 1'b0;
      epc_data_q    <= '0;
      exc_code_q    <= '0;
      bd_q          <= 1'b0;
      flush_q       <= 1'b0;
      stall_req_q   <= 1'b0;
      pc_redirect_q <= 1'b0;
      redirect_pc_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ev_pc_q       <= ev_pc_d;
      ev_code_q     <= ev_code_d;
      ev_bd_q       <= ev_bd_d;
      exl_set_q     <= exl_set_d;
      exl_clr_q     <= exl_clr_d;
      epc_we_q      <= epc_we_d;
      epc_data_q    <= epc_data_d;
      exc_code_q    <= exc_code_d;
      bd_q          <= bd_d;
      flush_q       <= flush_d;
      stall_req_q   <= stall_req_d;
      pc_redirect_q <= pc_redirect_d;
      redirect_pc_q <= redirect_pc_d;
      busy_q        <= busy_d;
    end
  end

  assign exl_set     = exl_set_q;
  assign exl_clr     = exl_clr_q;
  assign epc_we      = epc_we_q;
  assign epc_data    = epc_data_q;
  assign exc_code    = exc_code_q;
  assign bd          = bd_q;
  assign flush       = flush_q;
  assign stall_req   = stall_req_q;
  assign pc_redirect = pc_redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Bench for exc_entry_ctrl: directed literal scenarios followed by randomized traffic,
// all cycles checked against a cycle-level behavioural model of the entry/return rules.
module tb_exc_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_exc;
  logic [4:0]  m_exc_code;
  logic        m_is_eret;
  logic        int_req;
  logic [31:0] cp0_epc;
  logic        mem_busy;
  logic        exl_set, exl_clr, epc_we, bd, flush, stall_req, pc_redirect, busy;
  logic [31:0] epc_data, redirect_pc;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  exc_entry_ctrl dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc(m_exc), .m_exc_code(m_exc_code), .m_is_eret(m_is_eret),
    .int_req(int_req), .cp0_epc(cp0_epc), .mem_busy(mem_busy),
    .exl_set(exl_set), .exl_clr(exl_clr), .epc_we(epc_we), .epc_data(epc_data),
    .exc_code(exc_code), .bd(bd), .flush(flush), .stall_req(stall_req),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs for the cycle after each edge
  typedef struct {
    logic        exl_set, exl_clr, epc_we, flush, stall, redir, busy, bd;
    logic [31:0] epc_data, rpc;
    logic [4:0]  code;
  } exp_t;

  exp_t        e = '{default: 0};
  bit          pend = 0;
  int          owe = 0;
  logic [31:0] ev_pc = '0;
  logic [4:0]  ev_code = '0;
  logic        ev_bd = 1'b0;
  bit          chk_en = 0;

  task automatic model_fire();
    e.exl_set  = 1'b1;
    e.epc_we   = 1'b1;
    e.redir    = 1'b1;
    e.flush    = 1'b1;
    e.busy     = 1'b1;
    e.epc_data = ev_pc;
    e.code     = ev_code;
    e.bd       = ev_bd;
    e.rpc      = 32'h0000_4180;
    owe        = 2 - 1;
  endtask

  always @(posedge clk) begin
    bit was_busy;
    was_busy  = e.busy;
    e.exl_set = 0; e.exl_clr = 0; e.epc_we = 0; e.flush = 0;
    e.stall   = 0; e.redir = 0; e.busy = 0;
    if (reset) begin
      e    = '{default: 0};
      pend = 0;
      owe  = 0;
    end else if (pend) begin
      if (!mem_busy) begin
        pend = 0;
        model_fire();
      end else begin
        e.stall = 1'b1;
        e.busy  = 1'b1;
      end
    end else if (owe > 0) begin
      owe--;
      e.flush = 1'b1;
      e.busy  = 1'b1;
    end else if (!was_busy && m_valid === 1'b1) begin
      if (int_req || m_exc) begin
        ev_pc   = m_bd ? m_pc - 32'd4 : m_pc;
        ev_bd   = m_bd;
        ev_code = int_req ? 5'd0 : m_exc_code;
        if (mem_busy) begin
          pend    = 1;
          e.stall = 1'b1;
          e.busy  = 1'b1;
        end else begin
          model_fire();
        end
      end else if (m_is_eret) begin
        e.exl_clr = 1'b1;
        e.redir   = 1'b1;
        e.flush   = 1'b1;
        e.busy    = 1'b1;
        e.rpc     = cp0_epc;
      end
    end
  end

  // Compare process: every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("exl_set", 32'(exl_set), 32'(e.exl_set));
      chk("exl_clr", 32'(exl_clr), 32'(e.exl_clr));
      chk("epc_we", 32'(epc_we), 32'(e.epc_we));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("stall_req", 32'(stall_req), 32'(e.stall));
      chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("stall_with_redirect", 32'(stall_req & pc_redirect), 32'd0);
      if (e.epc_we) begin
        chk("epc_data", epc_data, e.epc_data);
        chk("exc_code", 32'(exc_code), 32'(e.code));
        chk("bd", 32'(bd), 32'(e.bd));
      end
      if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    m_valid = 0; m_exc = 0; m_is_eret = 0; int_req = 0; mem_busy = 0; m_bd = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero_ctrl"}, 32'({exl_set, exl_clr, epc_we, bd, flush, stall_req, pc_redirect, busy}), 32'd0);
    chk({tag, "_zero_epc"}, epc_data, 32'd0);
    chk({tag, "_zero_rpc"}, redirect_pc, 32'd0);
    chk({tag, "_zero_code"}, 32'(exc_code), 32'd0);
  endtask

  initial begin
    reset = 1; clear_in(); m_pc = '0; m_exc_code = '0; cp0_epc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 0;
    chk_en = 1;
    step();

    // Plain exception, no delay slot
    m_valid = 1; m_exc = 1; m_exc_code = 5'd10; m_pc = 32'h3010; m_bd = 0;
    step(); clear_in();
    chk("t1_exl_set", 32'(exl_set), 32'd1);
    chk("t1_epc_we", 32'(epc_we), 32'd1);
    chk("t1_redirect", 32'(pc_redirect), 32'd1);
    chk("t1_epc_data", epc_data, 32'h3010);
    chk("t1_exc_code", 32'(exc_code), 32'd10);
    chk("t1_redirect_pc", redirect_pc, 32'h4180);
    chk("t1_flush", 32'(flush), 32'd1);
    step();
    chk("t1_flush2", 32'(flush), 32'd1);
    chk("t1_pulse_end", 32'(exl_set | epc_we | pc_redirect), 32'd0);
    step();
    chk("t1_flush_off", 32'(flush), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Delay slot: EPC points at the branch
    m_valid = 1; m_exc = 1; m_exc_code = 5'd10; m_pc = 32'h3024; m_bd = 1;
    step(); clear_in();
    chk("t2_epc_data", epc_data, 32'h3020);
    chk("t2_bd", 32'(bd), 32'd1);
    step(); step();

    // Interrupt beats exception
    m_valid = 1; int_req = 1; m_exc = 1; m_exc_code = 5'd12; m_pc = 32'h3100;
    step(); clear_in();
    chk("t3_int_code", 32'(exc_code), 32'd0);
    chk("t3_int_entry", 32'(exl_set), 32'd1);
    step(); step();
    // Interrupt on a bubble is deferred
    int_req = 1; m_valid = 0; m_pc = 32'h3200;
    step();
    chk("t3_bubble1", 32'(exl_set | busy), 32'd0);
    step();
    chk("t3_bubble2", 32'(exl_set | busy), 32'd0);
    m_valid = 1;
    step(); clear_in();
    chk("t3_deferred_entry", 32'(exl_set), 32'd1);
    chk("t3_deferred_epc", epc_data, 32'h3200);
    step(); step();

    // Entry waits for mem_busy, captured PC survives M-stage changes
    m_valid = 1; m_exc = 1; m_exc_code = 5'd4; m_pc = 32'h5000; mem_busy = 1;
    step();
    m_pc = 32'h4000;
    chk("t4_stall1", 32'(stall_req), 32'd1);
    chk("t4_no_redir", 32'(pc_redirect), 32'd0);
    step();
    chk("t4_stall2", 32'(stall_req), 32'd1);
    step();
    chk("t4_stall3", 32'(stall_req), 32'd1);
    mem_busy = 0;
    step(); clear_in();
    chk("t4_stall_off", 32'(stall_req), 32'd0);
    chk("t4_entry", 32'(exl_set), 32'd1);
    chk("t4_epc_data", epc_data, 32'h5000);
    chk("t4_exc_code", 32'(exc_code), 32'd4);
    step(); step();

    // ERET return
    m_valid = 1; m_is_eret = 1; cp0_epc = 32'h3044;
    step(); clear_in();
    chk("t5_exl_clr", 32'(exl_clr), 32'd1);
    chk("t5_redirect", 32'(pc_redirect), 32'd1);
    chk("t5_redirect_pc", redirect_pc, 32'h3044);
    chk("t5_flush", 32'(flush), 32'd1);
    chk("t5_no_epc_we", 32'(epc_we | exl_set), 32'd0);
    step();
    chk("t5_flush_1cyc", 32'(flush | exl_clr | pc_redirect), 32'd0);

    // Reset during entry flush aborts with no further entry
    m_valid = 1; m_exc = 1; m_exc_code = 5'd7; m_pc = 32'h3300;
    step();
    chk("t6_entered", 32'(flush), 32'd1);
    reset = 1;
    step();
    chk_all_zero("t6");
    reset = 0; clear_in();
    step();
    chk("t6_quiet", 32'(exl_set | flush | busy), 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(63) == 0);
      m_valid    = ($urandom_range(1) == 1);
      m_pc       = {$urandom_range(32'hffff) , 16'h0} | 32'($urandom_range(255)) << 2;
      m_bd       = ($urandom_range(3) == 0);
      m_exc      = ($urandom_range(5) == 0);
      m_exc_code = 5'($urandom_range(31));
      m_is_eret  = ($urandom_range(5) == 0);
      int_req    = ($urandom_range(7) == 0);
      cp0_epc    = $urandom;
      mem_busy   = ($urandom_range(2) == 0);
      step();
    end
    reset = 0; clear_in();
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
